// File: rtl/serving_mem_arbiter.sv
// serving_mem_arbiter: round-robin two-master Wishbone arbiter with grant hold and ack watchdog
module serving_mem_arbiter #(
   parameter int WITH_TIMEOUT = 1,
   parameter int TIMEOUT_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_cpu_ibus_adr,
   input  logic        i_wb_cpu_ibus_stb,
   output logic [31:0] o_wb_cpu_ibus_rdt,
   output logic        o_wb_cpu_ibus_ack,
   input  logic [31:0] i_wb_cpu_dbus_adr,
   input  logic [31:0] i_wb_cpu_dbus_dat,
   input  logic [3:0]  i_wb_cpu_dbus_sel,
   input  logic        i_wb_cpu_dbus_we,
   input  logic        i_wb_cpu_dbus_stb,
   output logic [31:0] o_wb_cpu_dbus_rdt,
   output logic        o_wb_cpu_dbus_ack,
   output logic [31:0] o_wb_mem_adr,
   output logic [31:0] o_wb_mem_dat,
   output logic [3:0]  o_wb_mem_sel,
   output logic        o_wb_mem_we,
   output logic        o_wb_mem_stb,
   input  logic [31:0] i_wb_mem_rdt,
   input  logic        i_wb_mem_ack,
   output logic        o_timeout
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 last_q, last_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 gnt_i, gnt_d, act_i, act_d, to;

   always_comb begin
      // reset masks the grant so nothing leaks out while i_rst is high
      gnt_i = state_q == GNT_I && !i_rst;
      gnt_d = state_q == GNT_D && !i_rst;
      act_i = gnt_i && i_wb_cpu_ibus_stb;
      act_d = gnt_d && i_wb_cpu_dbus_stb;
      to = (WITH_TIMEOUT != 0) && (act_i || act_d) && !i_wb_mem_ack && (&cnt_q);
      o_wb_cpu_ibus_ack = act_i && (i_wb_mem_ack || to);
      o_wb_cpu_ibus_rdt = act_i && i_wb_mem_ack ? i_wb_mem_rdt : 32'd0;
      o_wb_cpu_dbus_ack = act_d && (i_wb_mem_ack || to);
      o_wb_cpu_dbus_rdt = act_d && i_wb_mem_ack ? i_wb_mem_rdt : 32'd0;
      o_timeout = to;
      o_wb_mem_stb = gnt_i || gnt_d;
      o_wb_mem_adr = gnt_i ? i_wb_cpu_ibus_adr : gnt_d ? i_wb_cpu_dbus_adr : 32'd0;
      o_wb_mem_dat = gnt_d ? i_wb_cpu_dbus_dat : 32'd0;
      o_wb_mem_sel = gnt_d ? i_wb_cpu_dbus_sel : 4'd0;
      o_wb_mem_we  = gnt_d && i_wb_cpu_dbus_we;
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (i_wb_cpu_ibus_stb && (!i_wb_cpu_dbus_stb || last_q))
            state_d = GNT_I;
         else if (i_wb_cpu_dbus_stb)
            state_d = GNT_D;
      end else if (!(act_i || act_d) || i_wb_mem_ack || to) begin
         state_d = IDLE;
         last_d  = state_q == GNT_D;
      end else
         cnt_d = WITH_TIMEOUT != 0 ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
